// File: rtl/flat_stream_serializer.sv
// flat_stream_serializer: captures one flattened WIDTH x HEIGHT frame in a single
// handshake and streams its elements row-major, one per beat, with position
// indices and an end-of-frame marker.
// Optional: define ROW_LAST_EN to add the out_row_last port (beat with j == HEIGHT-1).
module flat_stream_serializer #(
    parameter int WIDTH     = 4,
    parameter int HEIGHT    = 8,
    parameter int DATA_SIZE = 16,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int JW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH*HEIGHT*DATA_SIZE-1:0]   in_flat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_SIZE-1:0]                out_data,
    output logic [IW-1:0]                       out_i,
    output logic [JW-1:0]                       out_j,
    output logic                                out_last
`ifdef ROW_LAST_EN
    ,
    output logic                                out_row_last
`endif
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] I_MAX = IW'(WIDTH - 1);
    localparam logic [JW-1:0] J_MAX = JW'(HEIGHT - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] in_elem [N];
    logic [DATA_SIZE-1:0] frame   [N];
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_nxt;
    logic [IW-1:0]        i_nxt;
    logic [JW-1:0]        j_nxt;
    logic                 row_end;

    genvar g;
    for (g = 0; g < N; g++) begin : g_unpack
        assign in_elem[g] = in_flat[g*DATA_SIZE +: DATA_SIZE];
    end

    // Position of the beat following the current one (row-major walk)
    always_comb begin
        row_end = out_j == J_MAX;
        j_nxt   = row_end ? '0 : out_j + 1'b1;
        i_nxt   = row_end ? out_i + 1'b1 : out_i;
        k_nxt   = k + 1'b1;
    end

    // Frame capture and beat sequencing; every output is a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_i     <= '0;
            out_j     <= '0;
            out_last  <= 1'b0;
            k         <= '0;
`ifdef ROW_LAST_EN
            out_row_last <= 1'b0;
`endif
        end else if (state == IDLE) begin
            in_ready <= 1'b1;
            if (in_valid && in_ready) begin
                frame     <= in_elem;
                state     <= STREAM;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= in_elem[0];
                out_i     <= '0;
                out_j     <= '0;
                k         <= '0;
                out_last  <= N == 1;
`ifdef ROW_LAST_EN
                out_row_last <= HEIGHT == 1;
`endif
            end
        end else if (out_ready) begin
            if (out_last) begin
                state     <= IDLE;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
`ifdef ROW_LAST_EN
                out_row_last <= 1'b0;
`endif
            end else begin
                out_data <= frame[k_nxt];
                out_i    <= i_nxt;
                out_j    <= j_nxt;
                k        <= k_nxt;
                out_last <= (i_nxt == I_MAX) && (j_nxt == J_MAX);
`ifdef ROW_LAST_EN
                out_row_last <= j_nxt == J_MAX;
`endif
            end
        end
    end
endmodule

// File: tb/tb_flat_stream_serializer.sv
// tb_flat_stream_serializer: directed bench with a queue-based frame model and
// per-cycle comparison, plus hand-computed expectations at key points.
module tb_flat_stream_serializer;
    localparam int W  = 4;
    localparam int H  = 8;
    localparam int DS = 16;
    localparam int N  = W * H;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [N*DS-1:0] in_flat = '0;
    logic            in_ready, out_valid, out_last, row_last;
    logic [DS-1:0]   out_data;
    logic [1:0]      out_i;
    logic [2:0]      out_j;

    logic            u1_in_valid = 1'b0;
    logic            u1_out_ready = 1'b1;
    logic [DS-1:0]   u1_in_flat = 16'h00AB;
    logic            u1_in_ready, u1_out_valid, u1_out_last, u1_row_last;
    logic [DS-1:0]   u1_out_data;
    logic [0:0]      u1_out_i, u1_out_j;

    always #5 clk = ~clk;

    flat_stream_serializer #(.WIDTH(W), .HEIGHT(H), .DATA_SIZE(DS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flat(in_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_i(out_i), .out_j(out_j), .out_last(out_last)
`ifdef ROW_LAST_EN
        , .out_row_last(row_last)
`endif
    );

    flat_stream_serializer #(.WIDTH(1), .HEIGHT(1), .DATA_SIZE(DS)) u1 (
        .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_flat(u1_in_flat),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_data(u1_out_data),
        .out_i(u1_out_i), .out_j(u1_out_j), .out_last(u1_out_last)
`ifdef ROW_LAST_EN
        , .out_row_last(u1_row_last)
`endif
    );

`ifndef ROW_LAST_EN
    assign row_last    = 1'b0;
    assign u1_row_last = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: a frame is a queue of (data, i, j) beats in row-major order
    typedef struct {
        logic [DS-1:0] d;
        int            i;
        int            j;
    } beat_t;

    beat_t q[$];
    bit    m_ready = 1'b0;
    int    popped = 0;
    bit    en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
        end else if (q.size() == 0) begin
            if (m_ready && in_valid) begin
                for (int e = 0; e < N; e++) q.push_back('{in_flat[e*DS +: DS], e / H, e % H});
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else if (out_ready) begin
            void'(q.pop_front());
            popped++;
            if (q.size() == 0) m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_i", out_i, q[0].i);
                chk("out_j", out_j, q[0].j);
                chk("out_last", out_last, q.size() == 1);
`ifdef ROW_LAST_EN
                chk("out_row_last", row_last, q[0].j == H - 1);
`endif
            end else begin
                chk("idle_last", out_last, 0);
`ifdef ROW_LAST_EN
                chk("idle_row_last", row_last, 0);
`endif
            end
        end
    end

    function automatic logic [N*DS-1:0] pat(input int m, input int a);
        logic [N*DS-1:0] r;
        for (int e = 0; e < N; e++) r[e*DS +: DS] = 16'(e * m + a);
        return r;
    endfunction

    task automatic wait_last();
        int c;
        for (c = 0; c < 200; c++) begin
            if (out_valid && out_last && out_ready) break;
            @(negedge clk);
        end
        if (c == 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_last: got timeout, expected out_last");
        end
    endtask

    task automatic wait_pop(input int base, input int target);
        int c;
        for (c = 0; c < 200 && popped - base < target; c++) @(negedge clk);
        if (c == 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pop: got %0d beats, expected %0d", popped - base, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int  base, stall;
        bit  tog;
        repeat (3) begin
            @(negedge clk);
            en = 1'b1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_i", out_i, 0);
            chk("rst_out_j", out_j, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_row_last", row_last, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // single frame, full throughput
        in_flat = pat(16, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        base = popped;
        chk("f1_first_valid", out_valid, 1);
        chk("f1_first_data", out_data, 0);
        wait_last();
        chk("f1_last_data", out_data, 496);
        chk("f1_last_i", out_i, 3);
        chk("f1_last_j", out_j, 7);
        @(negedge clk);
        chk("f1_beats", popped - base, 32);
        chk("f1_done_in_ready", in_ready, 1);
        chk("f1_done_valid", out_valid, 0);

        // backpressure: alternating ready plus a 5-cycle stall at beat 10
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        base = popped;
        stall = 0;
        tog = 1'b0;
        for (int c = 0; c < 300 && popped - base < 32; c++) begin
            if (popped - base == 10 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                chk("stall_data", out_data, 160);
                chk("stall_i", out_i, 1);
                chk("stall_j", out_j, 2);
            end else begin
                tog = !tog;
                out_ready = tog;
            end
            @(negedge clk);
        end
        chk("bp_beats", popped - base, 32);
        chk("bp_stalls", stall, 5);
        out_ready = 1'b1;
        @(negedge clk);

        // in_valid held with a different pattern while streaming; back-to-back frame
        in_flat = pat(16, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_flat = '1;
        wait_last();
        chk("ign_last_data", out_data, 496);
        @(negedge clk);
        chk("gap_in_ready", in_ready, 1);
        chk("gap_out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("f2_first_valid", out_valid, 1);
        chk("f2_first_data", out_data, 16'hFFFF);
        chk("f2_first_i", out_i, 0);
        wait_last();
        @(negedge clk);

        // reset in the middle of a frame
        in_flat = pat(16, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        base = popped;
        wait_pop(base, 12);
        chk("mid_k12_data", out_data, 192);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_data", out_data, 0);
        @(negedge clk);
        chk("mid_rec_in_ready", in_ready, 1);
        in_flat = pat(3, 5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("restart_data", out_data, 5);
        chk("restart_j", out_j, 0);
        wait_last();
        chk("restart_last_data", out_data, 98);
        @(negedge clk);

        // 1x1 frame: the first beat is also the last
        u1_in_valid = 1'b1;
        @(negedge clk);
        u1_in_valid = 1'b0;
        chk("u1_valid", u1_out_valid, 1);
        chk("u1_data", u1_out_data, 16'h00AB);
        chk("u1_last", u1_out_last, 1);
        chk("u1_in_ready", u1_in_ready, 0);
`ifdef ROW_LAST_EN
        chk("u1_row_last", u1_row_last, 1);
`endif
        @(negedge clk);
        chk("u1_done_valid", u1_out_valid, 0);
        chk("u1_done_in_ready", u1_in_ready, 1);
        chk("u1_done_last", u1_out_last, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flat_stream_serializer.md
# flat_stream_serializer

Consumes one flattened 2-D feature map (the packed bus produced by the flatten stage) and emits its elements one per beat in row-major order over a valid/ready stream. It sits directly downstream of the flatten stage and feeds element-serial consumers such as MAC, pooling or activation units. Each frame is captured whole in one handshake. Elements are then streamed with position indices and an end-of-frame marker.

## Interface
- WIDTH, 4: outer dimension (index i), ≥1
- HEIGHT, 8: inner dimension (index j), ≥1
- DATA_SIZE, 16: element width in bits
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame present on in_flat
- in_ready  out  1  block can accept a frame (registered)
- in_flat  in  WIDTH*HEIGHT*DATA_SIZE  element [i][j] at bits [(i*HEIGHT+j)*DATA_SIZE +: DATA_SIZE]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_SIZE  current element
- out_i  out  max(1,$clog2(WIDTH))  outer index of current element
- out_j  out  max(1,$clog2(HEIGHT))  inner index of current element
- out_last  out  1  current beat is element [WIDTH-1][HEIGHT-1]
- out_row_last  out  1  only with ROW_LAST_EN; current beat has j==HEIGHT-1

## Operation
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - A frame is accepted on a cycle with in_valid && in_ready. On accept, in_flat is captured into the frame buffer, i=j=0, and the state moves to STREAM.
- STREAM:
  - in_ready=0, out_valid=1.
  - out_data is the buffered element [out_i][out_j].
  - A transfer occurs on out_valid && out_ready. On transfer, j increments. When j==HEIGHT-1, j wraps to 0 and i increments.
  - A transfer with out_last=1 returns the state to IDLE and sets in_ready=1.
- Output ordering: beat k = i*HEIGHT+j, for k = 0 … WIDTH*HEIGHT-1. No element is skipped or duplicated.
- in_valid and in_flat are ignored while in_ready=0. The buffer is written only on accept.
- out_last = (i==WIDTH-1)&&(j==HEIGHT-1), qualified by out_valid. With WIDTH=HEIGHT=1, the first beat is last.
- Reset mid-frame:
  - The remaining elements are dropped.
  - On the first clock edge with rst high, all state returns to its reset values.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_i=0, out_j=0, out_last=0, out_row_last=0, state IDLE.
- in_ready rises on the first edge with rst low.
- Latency: accept at edge t gives out_valid=1 and element [0][0] from edge t+1.
- Full throughput: one beat per cycle while out_ready=1.
- Frame period: WIDTH*HEIGHT+1 cycles minimum. After the last transfer at edge t, in_ready=1 from edge t; the next accept is at t+1 at the earliest, and its first beat is at t+2.
- Stall: while out_valid && !out_ready, out_data, out_i, out_j, out_last and out_row_last hold stable.
- out_valid never drops mid-frame except via reset.
- All outputs are functions of registered state only. There are no combinational paths from in_valid, out_ready or in_flat to any output.

## Configuration
- ROW_LAST_EN defined: the out_row_last port exists and is asserted, qualified by out_valid, on every beat with j==HEIGHT-1. It holds under stall like the other outputs.
- ROW_LAST_EN undefined: the out_row_last port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, WIDTH=4, HEIGHT=8, DATA_SIZE=16:
  - Hold rst 3 cycles -> all outputs 0 during reset.
  - in_ready=1 on the first edge after rst falls; out_valid stays 0.
- Single frame, element [i][j]=(i*8+j)*16, out_ready=1:
  - Accept -> 32 consecutive beats starting next cycle; beat k has out_data=k*16, out_i=k/8, out_j=k%8.
  - out_last only at k=31 (data 496); in_ready=1 on the same edge.
- Backpressure: out_ready alternating 1,0 from beat 0, plus out_ready held low 5 cycles at k=10:
  - data 160, out_i=1, out_j=2 held stable throughout the stall.
  - All 32 values arrive in order, no duplicates.
- Ignored input and frame gap: in_valid held high with a different in_flat pattern (all 0xFFFF) during streaming:
  - The buffer is unchanged and frame 1 completes.
  - Frame 2 (0xFFFF) is accepted one cycle after frame 1's last transfer, and its first beat follows one cycle later.
- Reset mid-frame: assert rst for 1 cycle at k=12:
  - Next edge: out_valid=0, in_ready=0; in_ready=1 one edge later.
  - A new frame restarts at k=0 with the new data.
- ROW_LAST_EN defined:
  - out_row_last high at k=7,15,23,31 only.
  - With WIDTH=1, HEIGHT=1, data 0x00AB: single beat with out_last=1 and out_row_last=1.
